// File: rtl/slip_cmd_ctrl.sv
// slip_cmd_ctrl: parses SLIP frames as register read/write commands and sequences an 8-bit register bus.
// Optional idle-byte watchdog is compiled in when SLIP_CMD_TIMEOUT_EN is defined.
module slip_cmd_ctrl #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame,
  input  logic [7:0]    din,
  input  logic          din_rdy,
  output logic          din_ack,
  output logic [AW-1:0] bus_addr,
  output logic [7:0]    bus_wdata,
  output logic          bus_we,
  output logic          bus_re,
  input  logic [7:0]    bus_rdata,
  input  logic          bus_ack,
  output logic [7:0]    tx_data,
  output logic          tx_rdy,
  output logic          tx_last,
  input  logic          tx_ack,
  output logic          busy,
  output logic [7:0]    err_cnt
);

  if (AW < 2 || AW > 16 || TIMEOUT < 1) begin : g_param_check
    $error("slip_cmd_ctrl: unsupported AW or TIMEOUT");
  end

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_WBUS,
    S_RCNT,
    S_RBUS,
    S_RSEND,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic          din_ack_q, din_ack_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          re_q, re_d;
  logic [7:0]    txd_q, txd_d;
  logic          txr_q, txr_d;
  logic          txl_q, txl_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [7:0]    err_q, err_d;

  logic          accept;
  logic          take;
  logic          frame_end;
  logic          err_inc;

`ifdef SLIP_CMD_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_watch;
`endif

  // din_rdy is ignored during the ack cycle so a held byte is never taken twice.
  always_comb begin
    accept    = state_q inside {S_CMD, S_ADDR, S_WDATA, S_RCNT, S_DRAIN};
    take      = accept && din_rdy && !din_ack_q;
    frame_end = !frame && !din_rdy;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      din_ack_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      txd_q     <= '0;
      txr_q     <= 1'b0;
      txl_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      din_ack_q <= din_ack_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      txd_q     <= txd_d;
      txr_q     <= txr_d;
      txl_q     <= txl_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end

`ifdef SLIP_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    din_ack_d = take;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    re_d      = re_q;
    txd_d     = txd_q;
    txr_d     = txr_q;
    txl_d     = txl_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    err_inc   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame) state_d = S_CMD;
      end
      S_CMD: begin
        if (take) begin
          if (din == CMD_WR) begin
            rd_d    = 1'b0;
            state_d = S_ADDR;
          end else if (din == CMD_RD) begin
            rd_d    = 1'b1;
            state_d = S_ADDR;
          end else begin
            err_inc = 1'b1;
            state_d = S_DRAIN;
          end
        end else if (frame_end) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (take) begin
          addr_d  = AW'(din);
          state_d = rd_q ? S_RCNT : S_WDATA;
        end else if (frame_end) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (take) begin
          wdata_d = din;
          we_d    = 1'b1;
          state_d = S_WBUS;
        end else if (frame_end) begin
          state_d = S_IDLE;
        end
      end
      S_WBUS: begin
        if (bus_ack) begin
          we_d    = 1'b0;
          addr_d  = addr_q + AW'(1);
          state_d = S_WDATA;
        end
      end
      S_RCNT: begin
        if (take) begin
          if (din == 8'h00) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d   = din;
            re_d    = 1'b1;
            state_d = S_RBUS;
          end
        end else if (frame_end) begin
          err_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RBUS: begin
        if (bus_ack) begin
          re_d    = 1'b0;
          txd_d   = bus_rdata;
          txr_d   = 1'b1;
          txl_d   = (cnt_q == 8'd1);
          state_d = S_RSEND;
        end
      end
      S_RSEND: begin
        if (tx_ack) begin
          txr_d = 1'b0;
          txl_d = 1'b0;
          cnt_d = cnt_q - 8'd1;
          if (cnt_q != 8'd1) begin
            addr_d  = addr_q + AW'(1);
            re_d    = 1'b1;
            state_d = S_RBUS;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!take && frame_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SLIP_CMD_TIMEOUT_EN
    // Expiry only applies when nothing else moved the state this cycle.
    wd_watch = state_q inside {S_CMD, S_ADDR, S_RCNT, S_WDATA};
    if (wd_watch && wd_q == WD_W'(TIMEOUT) && !take && state_d == state_q) begin
      err_inc = 1'b1;
      state_d = S_DRAIN;
    end
    if (take || state_d != state_q || !wd_watch) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    din_ack   = din_ack_q;
    bus_addr  = addr_q;
    bus_wdata = wdata_q;
    bus_we    = we_q;
    bus_re    = re_q;
    tx_data   = txd_q;
    tx_rdy    = txr_q;
    tx_last   = txl_q;
    err_cnt   = err_q;
  end

endmodule

// File: tb/tb_slip_cmd_ctrl.sv
// Directed bench for slip_cmd_ctrl: vector table of single-byte commands plus hand-written sequences.
module tb_slip_cmd_ctrl;
  localparam int unsigned AW = 8;
`ifdef SLIP_CMD_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 65535;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame = 1'b0;
  logic [7:0]    din = '0;
  logic          din_rdy = 1'b0;
  logic          din_ack;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_we;
  logic          bus_re;
  logic [7:0]    bus_rdata = '0;
  logic          bus_ack = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_rdy;
  logic          tx_last;
  logic          tx_ack = 1'b0;
  logic          busy;
  logic [7:0]    err_cnt;

  slip_cmd_ctrl #(.AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .frame(frame), .din(din), .din_rdy(din_rdy), .din_ack(din_ack),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .tx_last(tx_last), .tx_ack(tx_ack), .busy(busy), .err_cnt(err_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int exp_err = 0;

  int ack_dly = 2;
  int tx_dly = 0;
  int bwait = 0;
  int twait = 0;
  int ack_cnt = 0;
  logic ack_prev = 1'b0;
  logic [7:0] t_hold = '0;
  logic       tl_hold = 1'b0;
  int viol_we_re = 0, viol_re_tx = 0, viol_stab = 0, viol_dbl = 0, viol_last = 0;

  logic [7:0] wr_a[$];
  logic [7:0] wr_d[$];
  logic [7:0] rd_a[$];
  logic [7:0] tx_b[$];
  logic       tx_l[$];

  typedef struct {
    logic [7:0] cmd, addr, pay;
    int         nwr, nrd, ntx;
    logic [7:0] eaddr, eval;
    logic       elast;
    int         derr;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bus slave: acks each request after ack_dly idle cycles, read data = ~address.
  initial forever begin
    @(negedge clk);
    if (bus_ack) begin
      bus_ack = 1'b0;
    end else if (rst && (bus_we || bus_re)) begin
      if (bwait >= ack_dly) begin
        bwait = 0;
        bus_ack = 1'b1;
        if (bus_re) begin
          bus_rdata = ~bus_addr;
          rd_a.push_back(bus_addr);
        end else begin
          wr_a.push_back(bus_addr);
          wr_d.push_back(bus_wdata);
        end
      end else begin
        bwait++;
      end
    end else begin
      bwait = 0;
    end
  end

  // Tx sink and protocol monitors.
  initial forever begin
    @(negedge clk);
    if (bus_we && bus_re) viol_we_re++;
    if (bus_re && tx_rdy) viol_re_tx++;
    if (tx_last && !tx_rdy) viol_last++;
    if (din_ack) begin
      ack_cnt++;
      if (ack_prev) viol_dbl++;
    end
    ack_prev = din_ack;
    if (tx_ack) begin
      tx_ack = 1'b0;
    end else if (tx_rdy) begin
      if (twait == 0) begin
        t_hold = tx_data;
        tl_hold = tx_last;
      end else if (tx_data != t_hold || tx_last != tl_hold) begin
        viol_stab++;
      end
      if (twait >= tx_dly) begin
        tx_b.push_back(tx_data);
        tx_l.push_back(tx_last);
        tx_ack = 1'b1;
        twait = 0;
      end else begin
        twait++;
      end
    end else begin
      twait = 0;
    end
  end

  // Present a byte, hold din_rdy through the ack cycle, then release.
  task automatic send_byte(input logic [7:0] b, input logic fr);
    int n;
    @(negedge clk);
    din = b;
    din_rdy = 1'b1;
    frame = fr;
    n = 0;
    while (!din_ack && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!din_ack) check("byte_ack_timeout", din_ack, 1);
    @(negedge clk);
    din_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); rd_a.delete(); tx_b.delete(); tx_l.delete();
    ack_cnt = 0;
  endtask

  task automatic bump_err(input int d);
    exp_err += d;
    if (exp_err > 255) exp_err = 255;
  endtask

  initial begin
    logic [7:0] ea[3];
    logic [7:0] et[3];
    logic       el[3];

    vecs[0] = '{8'h01, 8'h33, 8'h5A, 1, 0, 0, 8'h33, 8'h5A, 1'b0, 0};
    vecs[1] = '{8'h01, 8'hFF, 8'hC3, 1, 0, 0, 8'hFF, 8'hC3, 1'b0, 0};
    vecs[2] = '{8'h02, 8'h40, 8'h01, 0, 1, 1, 8'h40, 8'hBF, 1'b1, 0};
    vecs[3] = '{8'h02, 8'h00, 8'h01, 0, 1, 1, 8'h00, 8'hFF, 1'b1, 0};
    vecs[4] = '{8'h02, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1'b0, 0};
    vecs[5] = '{8'h07, 8'h55, 8'h66, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1};
    vecs[6] = '{8'h00, 8'hAA, 8'h55, 0, 0, 0, 8'h00, 8'h00, 1'b0, 1};
    vecs[7] = '{8'h02, 8'h81, 8'h01, 0, 1, 1, 8'h81, 8'h7E, 1'b1, 0};

    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus_we, bus_re, tx_rdy, tx_last, din_ack, busy}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_err", err_cnt, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      clear_logs();
      send_byte(vecs[i].cmd, 1'b1);
      send_byte(vecs[i].addr, 1'b1);
      send_byte(vecs[i].pay, 1'b1);
      frame = 1'b0;
      wait_idle($sformatf("v%0d_idle", i));
      bump_err(vecs[i].derr);
      check($sformatf("v%0d_nwr", i), wr_a.size(), vecs[i].nwr);
      check($sformatf("v%0d_nrd", i), rd_a.size(), vecs[i].nrd);
      check($sformatf("v%0d_ntx", i), tx_b.size(), vecs[i].ntx);
      check($sformatf("v%0d_acks", i), ack_cnt, 3);
      check($sformatf("v%0d_err", i), err_cnt, exp_err);
      if (vecs[i].nwr > 0 && wr_a.size() > 0) begin
        check($sformatf("v%0d_waddr", i), wr_a[0], vecs[i].eaddr);
        check($sformatf("v%0d_wdata", i), wr_d[0], vecs[i].eval);
      end
      if (vecs[i].nrd > 0 && rd_a.size() > 0)
        check($sformatf("v%0d_raddr", i), rd_a[0], vecs[i].eaddr);
      if (vecs[i].ntx > 0 && tx_b.size() > 0) begin
        check($sformatf("v%0d_tx", i), tx_b[0], vecs[i].eval);
        check($sformatf("v%0d_last", i), tx_l[0], vecs[i].elast);
      end
    end

    // Two-byte write burst with address increment.
    clear_logs();
    send_byte(8'h01, 1'b1); send_byte(8'h10, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    frame = 1'b0;
    wait_idle("wr2_idle");
    check("wr2_n", wr_a.size(), 2);
    if (wr_a.size() == 2) begin
      check("wr2_a0", wr_a[0], 8'h10); check("wr2_d0", wr_d[0], 8'hAA);
      check("wr2_a1", wr_a[1], 8'h11); check("wr2_d1", wr_d[1], 8'hBB);
    end
    check("wr2_err", err_cnt, exp_err);

    // Three-byte read across the address wrap, frame dropped early.
    clear_logs();
    send_byte(8'h02, 1'b1); send_byte(8'hFE, 1'b1); send_byte(8'h03, 1'b1);
    frame = 1'b0;
    wait_idle("rd3_idle");
    ea = '{8'hFE, 8'hFF, 8'h00};
    et = '{8'h01, 8'h00, 8'hFF};
    el = '{1'b0, 1'b0, 1'b1};
    check("rd3_nrd", rd_a.size(), 3);
    check("rd3_ntx", tx_b.size(), 3);
    if (rd_a.size() == 3 && tx_b.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rd3_addr%0d", k), rd_a[k], ea[k]);
        check($sformatf("rd3_tx%0d", k), tx_b[k], et[k]);
        check($sformatf("rd3_last%0d", k), tx_l[k], el[k]);
      end
    end

    // Slow tx consumer: data must hold and no new read may start before tx_ack.
    clear_logs();
    tx_dly = 10;
    send_byte(8'h02, 1'b1); send_byte(8'h20, 1'b1); send_byte(8'h03, 1'b1);
    frame = 1'b0;
    wait_idle("slow_idle");
    tx_dly = 0;
    check("slow_ntx", tx_b.size(), 3);
    if (tx_b.size() == 3) check("slow_tx2", tx_b[2], 8'hDD);
    check("slow_stable", viol_stab, 0);
    check("slow_re_vs_tx", viol_re_tx, 0);

    // Truncated after CMD, truncated in RCNT.
    clear_logs();
    send_byte(8'h01, 1'b1);
    frame = 1'b0;
    wait_idle("trunc_cmd_idle");
    bump_err(1);
    check("trunc_cmd_err", err_cnt, exp_err);
    send_byte(8'h02, 1'b1); send_byte(8'h50, 1'b1);
    frame = 1'b0;
    wait_idle("trunc_rcnt_idle");
    bump_err(1);
    check("trunc_rcnt_err", err_cnt, exp_err);
    check("trunc_nbus", wr_a.size() + rd_a.size(), 0);

    // Data byte arrives together with frame low: written, then clean end.
    clear_logs();
    send_byte(8'h01, 1'b1); send_byte(8'h50, 1'b1); send_byte(8'h77, 1'b0);
    wait_idle("order_idle");
    check("order_nwr", wr_a.size(), 1);
    if (wr_a.size() == 1) check("order_wdata", wr_d[0], 8'h77);
    check("order_err", err_cnt, exp_err);

`ifdef SLIP_CMD_TIMEOUT_EN
    clear_logs();
    send_byte(8'h01, 1'b1); send_byte(8'h10, 1'b1);
    repeat (40) @(negedge clk);
    bump_err(1);
    check("wd_err", err_cnt, exp_err);
    check("wd_drain_busy", busy, 1);
    frame = 1'b0;
    wait_idle("wd_idle");
    check("wd_nwr", wr_a.size(), 0);
`endif

    // Reset while a write request is pending.
    clear_logs();
    ack_dly = 50;
    send_byte(8'h01, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'hAA, 1'b1);
    check("mid_we_up", bus_we, 1);
    rst = 1'b0;
    frame = 1'b0;
    @(negedge clk);
    check("mid_rst_ctrl", {bus_we, bus_re, tx_rdy, tx_last, din_ack, busy}, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_wdata", bus_wdata, 0);
    check("mid_rst_err", err_cnt, 0);
    exp_err = 0;
    rst = 1'b1;
    ack_dly = 2;
    repeat (3) @(negedge clk);
    check("mid_rst_nwr", wr_a.size(), 0);

    // Error counter saturation.
    for (int j = 0; j < 260; j++) begin
      send_byte(8'hEE, 1'b1);
      frame = 1'b0;
      repeat (4) @(negedge clk);
      bump_err(1);
    end
    wait_idle("sat_idle");
    check("sat_err", err_cnt, exp_err);

    check("we_re_overlap", viol_we_re, 0);
    check("din_ack_width", viol_dbl, 0);
    check("last_without_rdy", viol_last, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/slip_cmd_ctrl.md
Name: slip_cmd_ctrl

Overview:
Command sequencer behind the SLIP receiver. It consumes decoded bytes and the frame flag, parses each frame as a register-access command, and drives an 8-bit register bus. Read data is returned as a byte stream toward the SLIP transmit path. It owns all bus sequencing for the host link and keeps a saturating error counter for malformed frames.

Parameters:
AW, 8, register bus address width (2..16)
TIMEOUT, 65535, idle-byte watchdog limit in clk cycles (used only with SLIP_CMD_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
frame  input  1  high while the SLIP receiver is inside a frame
din  input  8  decoded byte
din_rdy  input  1  decoded byte valid (level, held until acked)
din_ack  output  1  one-cycle consume pulse
bus_addr  output  AW  register address
bus_wdata  output  8  write data
bus_we  output  1  write request, held until bus_ack
bus_re  output  1  read request, held until bus_ack
bus_rdata  input  8  read data, valid with bus_ack on read
bus_ack  input  1  bus transfer complete (1 cycle)
tx_data  output  8  read-back byte
tx_rdy  output  1  tx_data valid, held until tx_ack
tx_last  output  1  marks last read-back byte of a command
tx_ack  input  1  tx byte taken
busy  output  1  high in any state other than IDLE
err_cnt  output  8  saturating malformed-frame count

Behaviour:
- Reset: rst low at a clk edge forces state IDLE. All outputs go to 0. The address and count registers go to 0. This applies mid-transaction: any open bus_we/bus_re/tx_rdy is dropped immediately.
- Byte consume: a byte is taken when din_rdy=1 in a state that accepts bytes. din_ack is registered and goes high the following cycle for exactly 1 cycle. din_rdy is ignored while din_ack=1, so the same byte is never counted twice.
- Frame format: CMD, ADDR (low AW bits used; if AW>8, upper bits are 0), then payload.
- CMD 0x01 is a write; the payload is data bytes.
- CMD 0x02 is a read; the payload is a COUNT byte.
- States: IDLE, CMD, ADDR, WDATA, WBUS, RCNT, RBUS, RSEND, DRAIN.
- IDLE: frame=1 -> CMD.
- CMD: 0x01 -> ADDR (write). 0x02 -> ADDR (read). Any other value -> err_cnt+1, then DRAIN.
- ADDR: latch the address, then go to WDATA (write) or RCNT (read).
- WDATA: on a byte, latch bus_wdata, assert bus_we, go to WBUS.
- WBUS: on bus_ack, drop bus_we, address +1 (wraps mod 2^AW), return to WDATA. No bytes are accepted while in WBUS.
- RCNT: COUNT=0 -> DRAIN with no bus activity. COUNT>0 -> latch COUNT, assert bus_re, go to RBUS.
- RBUS: on bus_ack, drop bus_re, latch bus_rdata into tx_data, assert tx_rdy, go to RSEND. tx_last=1 when the remaining count is 1.
- RSEND: on tx_ack, drop tx_rdy/tx_last and decrement the count. If the count is nonzero: address +1 (wraps), assert bus_re, go to RBUS. If the count is zero: go to DRAIN.
- DRAIN: consume and discard bytes. When frame=0 and din_rdy=0, go to IDLE.
- Frame end: in CMD, ADDR or RCNT, frame=0 with din_rdy=0 is a truncated frame: err_cnt+1, go to IDLE. In WDATA, the same condition is normal end-of-write: go to IDLE.
- In WBUS, RBUS and RSEND, frame=0 is ignored until the transaction completes. Read replies are always completed even if the frame ends early.
- Bytes arriving during RBUS/RSEND stay pending. They are drained in DRAIN and are not an error.
- Ordering: if din_rdy=1 and frame=0 in the same cycle, the byte is processed first and the frame end is evaluated afterwards.
- err_cnt saturates at 0xFF.
- Latencies: write byte sampled to bus_we = 1 cycle. CMD 0x02 COUNT sampled to bus_re = 1 cycle. bus_ack to tx_rdy = 1 cycle.
- bus_we and bus_re are never high together. bus_addr and bus_wdata are stable while a request is high.

Optional Feature:
SLIP_CMD_TIMEOUT_EN
- Defined: a watchdog counter resets on every consumed byte and on entry to CMD/ADDR/RCNT/WDATA. If it reaches TIMEOUT while in CMD, ADDR, RCNT or WDATA, then err_cnt+1 and go to DRAIN. The watchdog is inactive in WBUS, RBUS, RSEND and DRAIN.
- Undefined: no counter logic; those states wait indefinitely.

Test Plan:
- Frame 01 10 AA BB, bus_ack 2 cycles after each request -> writes 0x10=AA, 0x11=BB; then IDLE, err_cnt=0.
- Frame 02 FE 03, AW=8, bus_rdata=addr^0xFF -> reads FE, FF, 00 (address wrap); tx bytes 01, 00, FF with tx_last on the third only.
- Frame 02 20 03 with tx_ack held off 10 cycles per byte -> tx_rdy/tx_data stable; the next bus_re is issued only after tx_ack.
- Frame 07 55 66 -> no bus activity, err_cnt=1, bytes 55 and 66 each acked exactly once, then IDLE.
- Frame 01 then frame drop -> err_cnt+1. Reset pulse during an active bus_we -> all outputs 0 next cycle, state IDLE.
- With SLIP_CMD_TIMEOUT_EN and TIMEOUT=16: send 01 10 then stall 16 cycles with frame high -> err_cnt+1, DRAIN, then IDLE once frame drops.
